// File: rtl/led_ctrl_pkg.sv
// Shared constants and FSM type for the mole-game RGB status LED controller.
package led_ctrl_pkg;

  localparam logic [2:0] GS_GAME_OVER  = 3'd3;
  localparam logic [2:0] GS_GAME_CLEAR = 3'd5;

  localparam logic [2:0] LED_ALL_ON = 3'b111;
  localparam logic [2:0] LED_OFF    = 3'b000;

  typedef enum logic [2:0] {
    FX_IDLE,
    FX_FLASH_HIT,
    FX_FLASH_MISS,
    FX_OVER_BLINK,
    FX_CLEAR_CHASE
  } led_fx_e;

endpackage

// File: rtl/led_tick_gen.sv
// Effect step timer: pulses tick every TICK_DIV cycles; clr restarts the count at 0.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_led_effect_ctrl.sv
// Arbitrates game-state effects and hit/miss flashes onto the three RGB status LEDs.
module rgb_led_effect_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned FLASH_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       hit_pulse,
  input  logic       miss_pulse,
  output logic [2:0] led_red,
  output logic [2:0] led_green,
  output logic [2:0] led_blue,
  output logic       busy
);

  localparam int unsigned FW = $clog2(2 * FLASH_COUNT + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_COUNT - 1);

  led_fx_e       fsm_q, fsm_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [2:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          entry;
  logic          tick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry),
    .tick (tick)
  );

  // entry marks any state entry (including a retrigger) so the step timer restarts.
  always_comb begin
    fsm_d   = fsm_q;
    flash_d = flash_q;
    entry   = 1'b0;
    if (state == GS_GAME_OVER) begin
      fsm_d = FX_OVER_BLINK;
      entry = (fsm_q != FX_OVER_BLINK);
    end else if (state == GS_GAME_CLEAR) begin
      fsm_d = FX_CLEAR_CHASE;
      entry = (fsm_q != FX_CLEAR_CHASE);
    end else if (fsm_q == FX_OVER_BLINK || fsm_q == FX_CLEAR_CHASE) begin
      fsm_d = FX_IDLE;
      entry = 1'b1;
    end else if (miss_pulse) begin
      fsm_d = FX_FLASH_MISS;
      entry = 1'b1;
    end else if (hit_pulse && fsm_q != FX_FLASH_MISS) begin
      fsm_d = FX_FLASH_HIT;
      entry = 1'b1;
    end else if (tick && (fsm_q == FX_FLASH_HIT || fsm_q == FX_FLASH_MISS)) begin
      if (flash_q == FLASH_LAST) begin
        fsm_d = FX_IDLE;
        entry = 1'b1;
      end else begin
        flash_d = flash_q + 1'b1;
      end
    end
    if (entry) flash_d = '0;

    // Outputs follow the next state so they change on the same edge as the FSM.
    red_d   = LED_OFF;
    green_d = LED_OFF;
    blue_d  = LED_OFF;
    case (fsm_d)
      FX_FLASH_HIT:   green_d = entry ? LED_ALL_ON : (tick ? ~green_q : green_q);
      FX_FLASH_MISS,
      FX_OVER_BLINK:  red_d   = entry ? LED_ALL_ON : (tick ? ~red_q : red_q);
      FX_CLEAR_CHASE: green_d = entry ? 3'b001 :
                                (tick ? {green_q[1:0], green_q[2]} : green_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= FX_IDLE;
      flash_q <= '0;
      red_q   <= LED_OFF;
      green_q <= LED_OFF;
      blue_q  <= LED_OFF;
    end else begin
      fsm_q   <= fsm_d;
      flash_q <= flash_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign led_red   = red_q;
  assign led_green = green_q;
  assign led_blue  = blue_q;
  assign busy      = (fsm_q != FX_IDLE);

endmodule

// File: tb/tb_rgb_led_effect_ctrl.sv
// Scoreboard bench: a cycle-count reference model predicts the LEDs for each edge.
module tb_rgb_led_effect_ctrl;

   localparam int TD = 4;
   localparam int FC = 2;

   typedef struct {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
      logic       busy;
   } exp_t;

   typedef enum {M_IDLE, M_HIT, M_MISS, M_OVER, M_CHASE} mmode_e;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] state = 3'd0;
   logic       hitPulse = 1'b0;
   logic       missPulse = 1'b0;
   logic [2:0] ledRed, ledGreen, ledBlue;
   logic       busy;

   exp_t   expQ[$];
   mmode_e mode = M_IDLE;
   int     elapsed = 0;
   int     checks = 0;
   int     passes = 0;

   rgb_led_effect_ctrl #(.TICK_DIV(TD), .FLASH_COUNT(FC)) dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .hit_pulse  (hitPulse),
      .miss_pulse (missPulse),
      .led_red    (ledRed),
      .led_green  (ledGreen),
      .led_blue   (ledBlue),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // The model tracks only the active effect and cycles elapsed since it began.
   function automatic exp_t modelOutputs();
      exp_t e;
      int   step;
      step   = elapsed / TD;
      e.r    = 3'b000;
      e.g    = 3'b000;
      e.b    = 3'b000;
      e.busy = (mode != M_IDLE);
      case (mode)
         M_HIT:   e.g = (step % 2 == 0) ? 3'b111 : 3'b000;
         M_MISS:  e.r = (step % 2 == 0) ? 3'b111 : 3'b000;
         M_OVER:  e.r = (step % 2 == 0) ? 3'b111 : 3'b000;
         M_CHASE: e.g = 3'(1 << (step % 3));
         default: ;
      endcase
      return e;
   endfunction

   task automatic modelStep(input logic [2:0] st, input logic hit, input logic miss);
      if (st == 3'd3) begin
         if (mode != M_OVER) begin mode = M_OVER; elapsed = 0; end
         else elapsed++;
      end else if (st == 3'd5) begin
         if (mode != M_CHASE) begin mode = M_CHASE; elapsed = 0; end
         else elapsed++;
      end else if (mode == M_OVER || mode == M_CHASE) begin
         mode = M_IDLE;
         elapsed = 0;
      end else if (miss) begin
         mode = M_MISS;
         elapsed = 0;
      end else if (hit && mode != M_MISS) begin
         mode = M_HIT;
         elapsed = 0;
      end else if (mode == M_HIT || mode == M_MISS) begin
         elapsed++;
         if (elapsed >= 2 * FC * TD) begin
            mode = M_IDLE;
            elapsed = 0;
         end
      end
   endtask

   task automatic checkOutput(input string name, input exp_t e);
      checks++;
      if (ledRed === e.r && ledGreen === e.g && ledBlue === e.b)
         passes++;
      else
         $display("[TB] FAIL %s leds: got r=%b g=%b b=%b, want r=%b g=%b b=%b (t=%0t)",
                  name, ledRed, ledGreen, ledBlue, e.r, e.g, e.b, $time);
      checks++;
      if (busy === e.busy)
         passes++;
      else
         $display("[TB] FAIL %s busy: got %b, want %b (t=%0t)", name, busy, e.busy, $time);
   endtask

   // One clock of stimulus: drive at the falling edge, queue what the next rising edge must show.
   task automatic applyStimulus(input logic [2:0] st, input logic hit, input logic miss);
      @(negedge clk);
      state     = st;
      hitPulse  = hit;
      missPulse = miss;
      modelStep(st, hit, miss);
      expQ.push_back(modelOutputs());
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(3'd0, 1'b0, 1'b0);
   endtask

   // Monitor: every rising edge is an output event; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("edge", e);
         end
      end
   end

   initial begin
      exp_t zero;
      logic [2:0] st;
      zero = '{r: 3'b000, g: 3'b000, b: 3'b000, busy: 1'b0};

      #2;
      checkOutput("reset", zero);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mode = M_IDLE;
      elapsed = 0;

      idleCycles(10);
      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(20);

      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(2);
      applyStimulus(3'd0, 1'b0, 1'b1);
      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(5);
      applyStimulus(3'd0, 1'b1, 1'b1);
      idleCycles(6);
      applyStimulus(3'd0, 1'b0, 1'b1);
      idleCycles(20);

      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(6);
      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(20);

      for (int i = 0; i < 20; i++) applyStimulus(3'd3, (i % 3) == 0, (i % 5) == 0);
      idleCycles(3);
      for (int i = 0; i < 16; i++) applyStimulus(3'd5, (i % 4) == 1, 1'b0);
      applyStimulus(3'd0, 1'b1, 1'b1);
      idleCycles(3);

      applyStimulus(3'd0, 1'b0, 1'b1);
      idleCycles(2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("async_reset", zero);
      @(negedge clk);
      rst = 1'b0;
      mode = M_IDLE;
      elapsed = 0;
      idleCycles(2);
      applyStimulus(3'd0, 1'b1, 1'b0);
      idleCycles(18);

      for (int seg = 0; seg < 60; seg++) begin
         int kind, len;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(3, 25);
         st   = (kind == 0) ? 3'd3 : (kind == 1) ? 3'd5 :
                (kind == 2) ? 3'($urandom_range(0, 7)) : 3'd0;
         for (int i = 0; i < len; i++)
            applyStimulus(st, $urandom_range(0, 9) == 0, $urandom_range(0, 13) == 0);
      end
      idleCycles(20);

      @(posedge clk);
      #2;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
